// File: rtl/dcpu16_fsbrg.sv
// DCPU16 fetch/store bus bridge: runs the FS stage request as a Wishbone
// classic cycle and owns the core-wide ena stall and pha phase signals.
module dcpu16_fsbrg #(
  parameter int unsigned TMO = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hlt,
  input  logic [15:0] fs_adr,
  input  logic        fs_stb,
  input  logic        fs_wre,
  input  logic [15:0] fs_dto,
  output logic [15:0] fs_dti,
  output logic        fs_ack,
  output logic        ena,
  output logic        pha,
  output logic        bus_err,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int unsigned CW = 4;
  localparam bit TMO_EN = (TMO != 0);
  // Timeout fires in the wait cycle whose incremented count would reach TMO.
  localparam logic [CW-1:0] TMO_LAST = (TMO == 0) ? '0 : CW'(TMO - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            tmo_hit;
  logic            launch;
  logic            fin_ack;
  logic            fin_err;

  assign tmo_hit = TMO_EN && (cnt == TMO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fs_stb) state_nxt = WAIT;
      WAIT:    if (wb_ack_i || wb_err_i || tmo_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: stall enable plus datapath controls
  always_comb begin
    ena     = 1'b0;
    launch  = 1'b0;
    fin_ack = 1'b0;
    fin_err = 1'b0;
    case (state)
      IDLE: begin
        ena    = !fs_stb && !hlt;
        launch = fs_stb;
      end
      WAIT: begin
        if (wb_ack_i)                 fin_ack = 1'b1;
        else if (wb_err_i || tmo_hit) fin_err = 1'b1;
      end
      DONE:    ena = 1'b1;
      default: ena = 1'b0;
    endcase
    if (rst) begin
      ena     = 1'b0;
      launch  = 1'b0;
      fin_ack = 1'b0;
      fin_err = 1'b0;
    end
  end

  // Registered bus, read data, phase and status
  always_ff @(posedge clk) begin
    if (rst) begin
      pha      <= 1'b0;
      fs_ack   <= 1'b0;
      bus_err  <= 1'b0;
      fs_dti   <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      cnt      <= '0;
    end else begin
      fs_ack <= fin_ack || fin_err;
      if (ena) pha <= ~pha;
      if (launch) begin
        wb_adr_o <= fs_adr;
        wb_dat_o <= fs_dto;
        wb_we_o  <= fs_wre;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        cnt      <= '0;
      end else if (fin_ack || fin_err) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
      end else if (state == WAIT && cnt != '1) begin
        cnt <= cnt + CW'(1);
      end
      if (fin_ack && !wb_we_o) fs_dti <= wb_dat_i;
      if (fin_err) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dcpu16_fsbrg.sv
// Self-checking bench for dcpu16_fsbrg: a cycle vector table, directed
// corner sequences and randomized transactions against a transaction model.
module tb_dcpu16_fsbrg;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        hlt;
  logic [15:0] fs_adr;
  logic        fs_stb;
  logic        fs_wre;
  logic [15:0] fs_dto;
  logic [15:0] fs_dti;
  logic        fs_ack;
  logic        ena;
  logic        pha;
  logic        bus_err;
  logic [15:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  dcpu16_fsbrg #(.TMO(TMO)) dut (
    .clk(clk), .rst(rst), .hlt(hlt),
    .fs_adr(fs_adr), .fs_stb(fs_stb), .fs_wre(fs_wre), .fs_dto(fs_dto),
    .fs_dti(fs_dti), .fs_ack(fs_ack), .ena(ena), .pha(pha), .bus_err(bus_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Model state: expected phase, read data and sticky error
  logic        m_pha;
  logic [15:0] m_dti;
  logic        m_berr;
  logic        cur_ena;

  typedef struct {
    logic        rst, hlt, stb, we, ack, err;
    logic [15:0] adr, dto, dat;
    logic        e_ena, e_stb, e_ack, e_berr;
    logic [15:0] e_dti, e_adr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; the phase model toggles on every enabled cycle
  task automatic tick();
    @(posedge clk);
    m_pha = rst ? 1'b0 : (m_pha ^ cur_ena);
    #1;
  endtask

  task automatic add(input logic r, h, s, w, a, e, input logic [15:0] adr, dto, dat,
                     input logic x_ena, x_stb, x_ack, x_berr, input logic [15:0] x_dti, x_adr);
    vec_t v;
    v.rst = r; v.hlt = h; v.stb = s; v.we = w; v.ack = a; v.err = e;
    v.adr = adr; v.dto = dto; v.dat = dat;
    v.e_ena = x_ena; v.e_stb = x_stb; v.e_ack = x_ack; v.e_berr = x_berr;
    v.e_dti = x_dti; v.e_adr = x_adr;
    vecs.push_back(v);
  endtask

  // One full request: IDLE launch, wait cycles, DONE, retire
  task automatic txn(input logic [15:0] adr, dto, rd, input bit we, input int k,
                     input bit is_err, input bit hlt_mid);
    int  n;
    bit  resp;
    resp = (k < TMO);
    n    = resp ? k + 1 : TMO;
    fs_adr = adr; fs_dto = dto; fs_wre = we; fs_stb = 1'b1;
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    #4; cur_ena = 1'b0;
    chk("req_ena", 32'(ena), 32'(0));
    chk("req_stb", 32'(wb_stb_o), 32'(0));
    tick();
    for (int i = 0; i < n; i++) begin
      if (hlt_mid && i == 1) hlt = 1'b1;
      wb_ack_i = (i == k) && !is_err;
      wb_err_i = (i == k) && is_err;
      wb_dat_i = (i == k) ? rd : 16'($urandom);
      #4; cur_ena = 1'b0;
      chk("wait_stb", 32'({wb_cyc_o, wb_stb_o}), 32'(3));
      chk("wait_adr", 32'(wb_adr_o), 32'(adr));
      chk("wait_we", 32'(wb_we_o), 32'(we));
      if (we) chk("wait_dat", 32'(wb_dat_o), 32'(dto));
      chk("wait_ena", 32'(ena), 32'(0));
      chk("wait_ack", 32'(fs_ack), 32'(0));
      chk("wait_pha", 32'(pha), 32'(m_pha));
      tick();
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    if (resp && !is_err && !we) m_dti = rd;
    if (!resp || is_err) m_berr = 1'b1;
    #4; cur_ena = 1'b1;
    chk("done_stb", 32'({wb_cyc_o, wb_stb_o}), 32'(0));
    chk("done_ack", 32'(fs_ack), 32'(1));
    chk("done_ena", 32'(ena), 32'(1));
    chk("done_dti", 32'(fs_dti), 32'(m_dti));
    chk("done_berr", 32'(bus_err), 32'(m_berr));
    chk("done_pha", 32'(pha), 32'(m_pha));
    tick();
    fs_stb = 1'b0;
    #4; cur_ena = !hlt;
    chk("post_ack", 32'(fs_ack), 32'(0));
    chk("post_stb", 32'(wb_stb_o), 32'(0));
    chk("post_ena", 32'(ena), 32'(!hlt));
    tick();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; hlt = 1'b0; fs_adr = '0; fs_stb = 1'b0; fs_wre = 1'b0; fs_dto = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    m_pha = 1'b0; m_dti = '0; m_berr = 1'b0; cur_ena = 1'b0;

    // rst hlt stb we ack err adr dto dat | ena stb ack berr dti adr
    add(1,0,0,0,0,0, 16'h0000,16'h0,16'h0000, 0,0,0,0, 16'h0000,16'h0000);
    add(1,0,0,0,0,0, 16'h0000,16'h0,16'h0000, 0,0,0,0, 16'h0000,16'h0000);
    add(0,0,0,0,0,0, 16'h0000,16'h0,16'h0000, 1,0,0,0, 16'h0000,16'h0000);
    add(0,0,0,0,0,0, 16'h0000,16'h0,16'h0000, 1,0,0,0, 16'h0000,16'h0000);
    add(0,0,0,0,0,0, 16'h0000,16'h0,16'h0000, 1,0,0,0, 16'h0000,16'h0000);
    add(0,0,0,0,0,0, 16'h0000,16'h0,16'h0000, 1,0,0,0, 16'h0000,16'h0000);
    add(0,0,1,0,0,0, 16'h0040,16'h0,16'h0000, 0,0,0,0, 16'h0000,16'h0000);
    add(0,0,1,0,1,0, 16'h0040,16'h0,16'hBEEF, 0,1,0,0, 16'h0000,16'h0040);
    add(0,0,1,0,0,0, 16'h0040,16'h0,16'h0000, 1,0,1,0, 16'hBEEF,16'h0040);
    add(0,0,0,0,0,0, 16'h0040,16'h0,16'h0000, 1,0,0,0, 16'hBEEF,16'h0040);
    add(0,0,1,0,0,0, 16'h0002,16'h0,16'h0000, 0,0,0,0, 16'hBEEF,16'h0040);
    add(0,0,1,0,1,1, 16'h0002,16'h0,16'h1111, 0,1,0,0, 16'hBEEF,16'h0002);
    add(0,0,1,0,0,0, 16'h0002,16'h0,16'h0000, 1,0,1,0, 16'h1111,16'h0002);
    add(0,0,0,0,0,0, 16'h0002,16'h0,16'h0000, 1,0,0,0, 16'h1111,16'h0002);

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; hlt = vecs[i].hlt; fs_stb = vecs[i].stb; fs_wre = vecs[i].we;
      wb_ack_i = vecs[i].ack; wb_err_i = vecs[i].err;
      fs_adr = vecs[i].adr; fs_dto = vecs[i].dto; wb_dat_i = vecs[i].dat;
      #4; cur_ena = vecs[i].e_ena;
      chk($sformatf("v%0d_ena", i), 32'(ena), 32'(vecs[i].e_ena));
      chk($sformatf("v%0d_stb", i), 32'({wb_cyc_o, wb_stb_o}), 32'({2{vecs[i].e_stb}}));
      chk($sformatf("v%0d_ack", i), 32'(fs_ack), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d_berr", i), 32'(bus_err), 32'(vecs[i].e_berr));
      chk($sformatf("v%0d_dti", i), 32'(fs_dti), 32'(vecs[i].e_dti));
      chk($sformatf("v%0d_adr", i), 32'(wb_adr_o), 32'(vecs[i].e_adr));
      chk($sformatf("v%0d_pha", i), 32'(pha), 32'(m_pha));
      tick();
    end
    m_dti = 16'h1111;

    // 3-wait write, then error, then timeout, then halt during a read
    txn(16'h1234, 16'hA5A5, 16'h0000, 1'b1, 3, 1'b0, 1'b0);
    txn(16'h0500, 16'h0000, 16'h7777, 1'b0, 1, 1'b1, 1'b0);
    txn(16'h0600, 16'h0000, 16'h0000, 1'b0, 10, 1'b0, 1'b0);
    txn(16'h0700, 16'h0000, 16'h4242, 1'b0, 2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #4; cur_ena = 1'b0;
      chk("hlt_ena", 32'(ena), 32'(0));
      chk("hlt_pha", 32'(pha), 32'(m_pha));
      tick();
    end
    hlt = 1'b0;
    #4; cur_ena = 1'b1;
    chk("unhlt_ena", 32'(ena), 32'(1));
    tick();

    // Reset on the second wait cycle
    fs_adr = 16'h0300; fs_wre = 1'b0; fs_stb = 1'b1;
    #4; cur_ena = 1'b0; chk("rw_req_ena", 32'(ena), 32'(0)); tick();
    #4; chk("rw_w0_stb", 32'(wb_stb_o), 32'(1)); tick();
    rst = 1'b1;
    #4; chk("rw_rst_ena", 32'(ena), 32'(0)); tick();
    rst = 1'b0; fs_stb = 1'b0; m_dti = '0; m_berr = 1'b0;
    #4; cur_ena = 1'b1;
    chk("rw_stb", 32'({wb_cyc_o, wb_stb_o}), 32'(0));
    chk("rw_ack", 32'(fs_ack), 32'(0));
    chk("rw_ena", 32'(ena), 32'(1));
    chk("rw_berr", 32'(bus_err), 32'(0));
    chk("rw_dti", 32'(fs_dti), 32'(0));
    chk("rw_pha", 32'(pha), 32'(m_pha));
    tick();
    #4; chk("rw_ack2", 32'(fs_ack), 32'(0)); tick();

    // Randomized transactions with idle gaps
    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        #4; cur_ena = 1'b1;
        chk("gap_ena", 32'(ena), 32'(1));
        chk("gap_pha", 32'(pha), 32'(m_pha));
        tick();
      end
      txn(16'($urandom), 16'($urandom), 16'($urandom), bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 6)), ($urandom_range(0, 5) == 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dcpu16_fsbrg.md
# dcpu16_fsbrg

Fetch/store bus bridge and pipeline sequencer for the DCPU16 core. It sits directly downstream of the FS bus stage. It takes that stage's registered request (`fs_adr`/`fs_stb`/`fs_wre`/`fs_dto`) and runs it as a Wishbone classic master cycle. It returns the read word on `fs_dti` and owns the core-wide `ena` stall and `pha` phase signals. While a bus cycle is outstanding or halted, `ena` is held low so that every stage freezes.

## Interface
- `TMO`, default 15: wait-state timeout in cycles, 4-bit; 0 disables the timeout.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `hlt`  in  1  debug halt; forces `ena` low in IDLE; does not abort an in-flight cycle.
- `fs_adr`  in  16  request word address (registered by the FS stage).
- `fs_stb`  in  1  request valid.
- `fs_wre`  in  1  1 = write, 0 = read.
- `fs_dto`  in  16  write data.
- `fs_dti`  out  16  read data; holds its value until the next read completes.
- `fs_ack`  out  1  one-cycle pulse when a request completes (ack, error or timeout).
- `ena`  out  1  core clock-enable (combinational from state).
- `pha`  out  1  phase; toggles on every cycle with `ena`=1.
- `bus_err`  out  1  sticky error flag; set by `wb_err_i` or timeout; cleared only by `rst`.
- `wb_adr_o`  out  16  Wishbone address.
- `wb_dat_o`  out  16  Wishbone write data.
- `wb_dat_i`  in  16  Wishbone read data.
- `wb_we_o`  out  1  Wishbone write enable.
- `wb_cyc_o`, `wb_stb_o`  out  1  Wishbone cycle and strobe; always driven equal.
- `wb_ack_i`, `wb_err_i`  in  1  Wishbone termination.

## Operation
- The FSM has three states: IDLE, WAIT and DONE. Reset enters IDLE.
- IDLE:
  - If `fs_stb`=1: latch `fs_adr`, `fs_dto` and `fs_wre` into the `wb_*` outputs, raise `cyc`/`stb`, and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - `wb_ack_i`=1: drop `cyc`/`stb`. If `we`=0, capture `wb_dat_i` into `fs_dti`. Go to DONE.
  - Else `wb_err_i`=1: drop `cyc`/`stb`, set `bus_err`, leave `fs_dti` unchanged, go to DONE.
  - Else, if the timeout counter reaches `TMO` and `TMO`≠0: same action as an error.
  - Otherwise increment the timeout counter. The counter is 4-bit, clears on entry to WAIT, and saturates.
- DONE: `fs_ack`=1 for this cycle only; go to IDLE unconditionally.
- `ena` = !rst & ((IDLE & !fs_stb & !hlt) | DONE).
  - `ena` is 1 in DONE even if `hlt`=1. This lets the FS stage retire the served request, so IDLE never relaunches the same request.
- `pha` <= ~`pha` on every cycle where `ena`=1.
- Priority: ack > err > timeout when they occur in the same cycle.
- On a write, `fs_dti` is not updated.
- Wishbone rule: `wb_adr_o`, `wb_dat_o` and `wb_we_o` are stable for the whole cycle while `cyc`=1.

## Timing
- Reset values:
  - State IDLE, `pha`=0, `fs_ack`=0, `bus_err`=0, `fs_dti`=0.
  - `wb_adr_o`=0, `wb_dat_o`=0, `wb_we_o`=0, `wb_cyc_o`=`wb_stb_o`=0, timeout counter 0.
  - `ena`=0 while `rst` is high.
- Request seen in cycle N (IDLE, `ena`=0): `stb` is high in N+1.
- Ack in cycle N+1+k (k wait states): `stb` is low and `fs_dti` valid in N+2+k (DONE, `ena`=1, `fs_ack`=1).
- Minimum stall is 2 cycles per access (k=0).
- Timeout with `TMO`=T: the error is taken T cycles after `stb` rises if no ack arrives first.
- `rst` mid-WAIT: `cyc`/`stb` drop on that edge, no `fs_ack` pulse, and `bus_err` is cleared.
- `hlt` asserted during WAIT: the cycle completes normally, DONE gives its one `ena` pulse, then `ena` stays 0 in IDLE until `hlt` falls.
- No request (`fs_stb`=0) and `hlt`=0: `ena`=1 every cycle and `pha` toggles every cycle.

## Test plan
- Reset: hold `rst` 2 cycles with `fs_stb`=0, then release.
  - Required: all outputs at their reset values while `rst` is high.
  - After release: `ena`=1 and `pha` reads 0,1,0,1.
- Zero-wait read: `fs_adr`=16'h0040, `fs_stb`=1, `fs_wre`=0; slave acks in the first `stb` cycle with 16'hBEEF.
  - Required: `stb` high exactly 1 cycle, `wb_adr_o`=16'h0040, `fs_dti`=16'hBEEF, `fs_ack` a 1-cycle pulse.
  - `ena` is 0,0,1 across the three cycles; no second cycle is issued.
- 3-wait write: `fs_adr`=16'h1234, `fs_dto`=16'hA5A5, `fs_wre`=1; ack after 3 wait cycles.
  - Required: `wb_we_o`=1 and `wb_dat_o`=16'hA5A5 stable for 4 cycles.
  - `fs_dti` unchanged; `ena` low 5 cycles, then high.
- Error and timeout:
  - `wb_err_i` pulse in WAIT: `bus_err`=1 stays set and the access completes via DONE.
  - With `TMO`=4 and no ack: `stb` high for 4 cycles, then `bus_err`=1.
  - Simultaneous ack+err: completes as ack, `bus_err` stays 0.
- Halt: `hlt`=1 issued mid-WAIT.
  - Required: DONE still gives one `ena` pulse, then `ena`=0 and `pha` frozen until `hlt`=0.
- Reset mid-WAIT: assert `rst` on the 2nd wait cycle.
  - Required: `cyc`/`stb`=0 on the next edge, no `fs_ack`, state IDLE.
